// File: rtl/i2s_receiver.sv
`default_nettype none
// i2s_receiver: 12-bit I2S capture framed only by word_select edges, publishing
// coherent left/right pairs with short-word detection and a lock indicator.
module i2s_receiver #(
  parameter int DATA_WIDTH = 12,
  parameter int BIT_CNT_W  = 5
) (
  input  logic                  s_clk,
  input  logic                  reset,
  input  logic                  word_select,
  input  logic                  sound_bit_in,
  output logic [DATA_WIDTH-1:0] left_out,
  output logic [DATA_WIDTH-1:0] right_out,
  output logic                  sample_valid,
  output logic                  frame_error,
  output logic                  locked
);

  typedef enum logic [2:0] {
    UNSYNC = 3'd0,
    LEFT   = 3'd1,
    WAIT_R = 3'd2,
    RIGHT  = 3'd3,
    WAIT_L = 3'd4
  } state_t;

  localparam logic [BIT_CNT_W-1:0] LAST_CNT = BIT_CNT_W'(DATA_WIDTH);

  state_t                state_q;
  logic                  ws_q;
  logic [BIT_CNT_W-1:0]  cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] hold_q;

  logic                  ws_edge;
  logic                  capturing;
  logic                  word_done;
  logic [BIT_CNT_W-1:0]  cnt_d;
  logic [DATA_WIDTH-1:0] shift_d;

  assign ws_edge   = (word_select != ws_q);
  assign capturing = (state_q == LEFT) || (state_q == RIGHT);
  assign shift_d   = {shift_q[DATA_WIDTH-2:0], sound_bit_in};
  assign cnt_d     = (cnt_q == LAST_CNT) ? cnt_q : cnt_q + BIT_CNT_W'(1);
  assign word_done = capturing && !ws_edge && (cnt_d == LAST_CNT);

  always_ff @(posedge s_clk or negedge reset) begin
    if (!reset) begin
      state_q      <= UNSYNC;
      ws_q         <= 1'b0;
      cnt_q        <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      left_out     <= '0;
      right_out    <= '0;
      sample_valid <= 1'b0;
      frame_error  <= 1'b0;
      locked       <= 1'b0;
    end else begin
      ws_q         <= word_select;
      sample_valid <= 1'b0;
      frame_error  <= 1'b0;
      if (ws_edge) begin
        // The bit at the edge is the I2S delay slot; the word restarts after it.
        cnt_q   <= '0;
        shift_q <= '0;
        if (capturing) begin
          frame_error <= 1'b1;
          locked      <= 1'b0;
        end
        if (!word_select) begin
          state_q <= LEFT;
        end else if (state_q == WAIT_R) begin
          state_q <= RIGHT;
        end else begin
          state_q <= UNSYNC;
        end
      end else if (capturing) begin
        cnt_q   <= cnt_d;
        shift_q <= shift_d;
        if (word_done) begin
          if (state_q == LEFT) begin
            hold_q  <= shift_d;
            state_q <= WAIT_R;
          end else begin
            left_out     <= hold_q;
            right_out    <= shift_d;
            sample_valid <= 1'b1;
            locked       <= 1'b1;
            state_q      <= WAIT_L;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2s_receiver.sv
`default_nettype none
// Bench for i2s_receiver: directed and random I2S traffic compared every cycle
// against a word-level reference model, plus literal checks on key scenarios.
module tb_i2s_receiver;
  localparam int DW = 12;

  logic          s_clk = 1'b0;
  logic          reset = 1'b0;
  logic          word_select;
  logic          sound_bit_in;
  logic [DW-1:0] left_out;
  logic [DW-1:0] right_out;
  logic          sample_valid;
  logic          frame_error;
  logic          locked;

  i2s_receiver #(.DATA_WIDTH(DW), .BIT_CNT_W(5)) dut (
    .s_clk        (s_clk),
    .reset        (reset),
    .word_select  (word_select),
    .sound_bit_in (sound_bit_in),
    .left_out     (left_out),
    .right_out    (right_out),
    .sample_valid (sample_valid),
    .frame_error  (frame_error),
    .locked       (locked)
  );

  always #5 s_clk = ~s_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fe_count = 0;
  int sv_times[$];

  // Word-level reference: each run of equal WS is one word; a left word is
  // always captured, a right word only if the word before it was a complete left.
  logic [DW-1:0] m_left, m_right, m_hold;
  logic          m_sv, m_fe, m_locked;
  logic          m_ws, m_seg_ch, m_seg_cap, m_prev_left_done;
  int            m_bits, m_word;

  task automatic model_init();
    m_left = '0; m_right = '0; m_hold = '0;
    m_sv = 1'b0; m_fe = 1'b0; m_locked = 1'b0;
    m_ws = 1'b0; m_seg_ch = 1'b0; m_seg_cap = 1'b0; m_prev_left_done = 1'b0;
    m_bits = 0; m_word = 0;
  endtask

  task automatic model_step(input logic ws, input logic b);
    m_sv = 1'b0;
    m_fe = 1'b0;
    if (ws != m_ws) begin
      if (m_seg_cap && m_bits < DW) begin
        m_fe = 1'b1;
        m_locked = 1'b0;
      end
      m_prev_left_done = (m_seg_ch == 1'b0) && m_seg_cap && (m_bits == DW);
      m_seg_ch  = ws;
      m_bits    = 0;
      m_word    = 0;
      m_seg_cap = (ws == 1'b0) ? 1'b1 : m_prev_left_done;
    end else if (m_seg_cap && m_bits < DW) begin
      m_word = m_word * 2 + int'(b);
      m_bits = m_bits + 1;
      if (m_bits == DW) begin
        if (m_seg_ch == 1'b0) begin
          m_hold = m_word[DW-1:0];
        end else begin
          m_left   = m_hold;
          m_right  = m_word[DW-1:0];
          m_sv     = 1'b1;
          m_locked = 1'b1;
        end
      end
    end
    m_ws = ws;
  endtask

  initial begin
    model_init();
    forever begin
      @(posedge s_clk or negedge reset);
      if (!reset) model_init();
      else model_step(word_select, sound_bit_in);
    end
  end

  initial forever begin
    @(posedge s_clk);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 'h%0h want 'h%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge s_clk);
    check("left_out", 32'(left_out), 32'(m_left));
    check("right_out", 32'(right_out), 32'(m_right));
    check("sample_valid", 32'(sample_valid), 32'(m_sv));
    check("frame_error", 32'(frame_error), 32'(m_fe));
    check("locked", 32'(locked), 32'(m_locked));
    if (sample_valid === 1'b1) sv_times.push_back(cyc);
    if (frame_error === 1'b1) fe_count = fe_count + 1;
  end

  task automatic drive_bit(input logic ws, input logic b);
    word_select  = ws;
    sound_bit_in = b;
    @(negedge s_clk);
  endtask

  // fill: 0 or 1 = constant filler bits after the word, 2 = random filler.
  task automatic send_word(input logic ws, input logic [DW-1:0] w, input int ndata,
                           input int extra, input int fill, input bit slot);
    if (slot) drive_bit(ws, 1'($urandom));
    for (int i = 0; i < ndata; i++) drive_bit(ws, w[DW-1-i]);
    for (int i = 0; i < extra; i++) drive_bit(ws, (fill == 2) ? 1'($urandom) : fill[0]);
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                            input int extra, input int fill);
    send_word(1'b0, l, DW, extra, fill, 1'b1);
    send_word(1'b1, r, DW, extra, fill, 1'b1);
  endtask

  task automatic check_pair(input string name, input logic [DW-1:0] l, input logic [DW-1:0] r);
    check({name, "_sv"}, 32'(sample_valid), 32'd1);
    check({name, "_left"}, 32'(left_out), 32'(l));
    check({name, "_right"}, 32'(right_out), 32'(r));
    check({name, "_locked"}, 32'(locked), 32'd1);
  endtask

  logic [DW-1:0] b2b_l [4];
  logic [DW-1:0] b2b_r [4];

  initial begin
    b2b_l[0] = 12'h000; b2b_r[0] = 12'hFFF;
    b2b_l[1] = 12'h800; b2b_r[1] = 12'h7FF;
    b2b_l[2] = 12'h001; b2b_r[2] = 12'hFFE;
    b2b_l[3] = 12'h555; b2b_r[3] = 12'hAAA;
    word_select  = 1'b0;
    sound_bit_in = 1'b0;

    // Reset held with random inputs.
    for (int i = 0; i < 6; i++) drive_bit(1'($urandom), 1'($urandom));
    check("rst_left", 32'(left_out), 32'd0);
    check("rst_right", 32'(right_out), 32'd0);
    check("rst_sv", 32'(sample_valid), 32'd0);
    check("rst_fe", 32'(frame_error), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    word_select = 1'b0;
    reset = 1'b1;
    @(negedge s_clk);

    // WS=1 first: must stay unsynchronised.
    send_word(1'b1, 12'hFFF, DW, 0, 0, 1'b1);
    #1;
    check("unsync_pulses", 32'(sv_times.size()), 32'd0);
    check("unsync_locked", 32'(locked), 32'd0);

    send_frame(12'hA5C, 12'h3F1, 0, 0);
    check_pair("nominal", 12'hA5C, 12'h3F1);
    check("nominal_fe", 32'(frame_error), 32'd0);
    #1;
    sv_times.delete();

    for (int f = 0; f < 4; f++) begin
      send_frame(b2b_l[f], b2b_r[f], 0, 0);
      check_pair("b2b", b2b_l[f], b2b_r[f]);
    end
    #1;
    check("b2b_pulses", 32'(sv_times.size()), 32'd4);
    for (int i = 1; i < sv_times.size(); i++)
      check("b2b_spacing", 32'(sv_times[i] - sv_times[i-1]), 32'd26);
    fe_count = 0;

    // Short right word: 7 data bits, then WS returns to 0.
    send_word(1'b0, 12'h123, DW, 0, 0, 1'b1);
    send_word(1'b1, 12'h456, 7, 0, 0, 1'b1);
    drive_bit(1'b0, 1'($urandom));
    check("short_fe", 32'(frame_error), 32'd1);
    check("short_locked", 32'(locked), 32'd0);
    check("short_left_hold", 32'(left_out), 32'h555);
    check("short_right_hold", 32'(right_out), 32'hAAA);
    send_word(1'b0, 12'h9C3, DW, 0, 0, 1'b0);
    send_word(1'b1, 12'h2B7, DW, 0, 0, 1'b1);
    check_pair("recover", 12'h9C3, 12'h2B7);
    #1;
    check("short_fe_count", 32'(fe_count), 32'd1);

    // Long words: 20-clock halves, trailing ones ignored.
    send_frame(12'h6D2, 12'h0E8, 7, 1);
    #1;
    check("long_left", 32'(left_out), 32'h6D2);
    check("long_right", 32'(right_out), 32'h0E8);
    check("long_locked", 32'(locked), 32'd1);
    check("long_fe_count", 32'(fe_count), 32'd1);
    @(negedge s_clk);

    // Asynchronous reset in the middle of a right word.
    send_word(1'b0, 12'h3C3, DW, 0, 0, 1'b1);
    send_word(1'b1, 12'hC3C, 5, 0, 0, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("arst_left", 32'(left_out), 32'd0);
    check("arst_right", 32'(right_out), 32'd0);
    check("arst_locked", 32'(locked), 32'd0);
    #1 reset = 1'b1;
    for (int i = 5; i < DW; i++) drive_bit(1'b1, 1'($urandom));
    check("arst_still_unlocked", 32'(locked), 32'd0);
    check("arst_no_pulse", 32'(sample_valid), 32'd0);
    send_frame(12'h7E1, 12'h18F, 0, 0);
    check_pair("resync", 12'h7E1, 12'h18F);

    // Random traffic with occasional short words.
    for (int f = 0; f < 40; f++) begin
      logic [DW-1:0] l, r;
      int kind;
      l = DW'($urandom);
      r = DW'($urandom);
      kind = int'($urandom_range(0, 7));
      if (kind == 0) begin
        send_word(1'b0, l, int'($urandom_range(0, DW-1)), 0, 0, 1'b1);
        send_word(1'b1, r, DW, int'($urandom_range(0, 3)), 2, 1'b1);
      end else if (kind == 1) begin
        send_word(1'b0, l, DW, int'($urandom_range(0, 3)), 2, 1'b1);
        send_word(1'b1, r, int'($urandom_range(0, DW-1)), 0, 0, 1'b1);
      end else begin
        send_frame(l, r, int'($urandom_range(0, 4)), 2);
      end
    end
    send_frame(12'hBEE, 12'h0C0, 1, 2);
    @(negedge s_clk);
    check("final_left", 32'(left_out), 32'hBEE);
    check("final_right", 32'(right_out), 32'h0C0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
